// File: rtl/fifo_stream_reader.sv
// Read-side adapter for the RAM-based FIFO: issues pops, captures the registered
// read data and re-presents it as a valid/ready stream through a 3-entry skid buffer.
module fifo_stream_reader #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 res,
  input  logic                 en,
  input  logic                 clr_cnt,
  input  logic                 fifo_empty,
  input  logic [WIDTH-1:0]     fifo_rdata,
  output logic                 fifo_shift_out,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIDTH-1:0]     out_data,
  output logic [CNT_WIDTH-1:0] words_out,
  output logic                 idle
);

  localparam int unsigned DEPTH = 3;

  logic [1:0]           occ_q, occ_d;
  logic [1:0]           head_q, head_d;
  logic [1:0]           tail_q, tail_d;
  logic                 pending_q, pending_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0]     mem_q [DEPTH];
  logic [WIDTH-1:0]     mem_d [DEPTH];
  logic [2:0]           committed;
  logic                 pop;
  logic                 consume;

  function automatic logic [1:0] ptr_inc(input logic [1:0] p);
    return (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

  assign out_valid      = (occ_q != 2'd0);
  assign out_data       = mem_q[head_q];
  assign words_out      = cnt_q;
  assign idle           = (occ_q == 2'd0) && !pending_q;
  assign fifo_shift_out = pop;

  always_comb begin
    // Counting the in-flight word as committed space is what makes overflow impossible.
    committed = {1'b0, occ_q} + {2'b00, pending_q};
    pop       = en && !fifo_empty && (committed < 3'd3) && !res;
    consume   = out_valid && out_ready;

    pending_d = pop;
    head_d    = head_q;
    tail_d    = tail_q;
    mem_d     = mem_q;
    cnt_d     = cnt_q;

    if (pending_q) begin
      mem_d[tail_q] = fifo_rdata;
      tail_d        = ptr_inc(tail_q);
    end
    if (consume) begin
      head_d = ptr_inc(head_q);
    end
    occ_d = occ_q + {1'b0, pending_q} - {1'b0, consume};

    if (clr_cnt) begin
      cnt_d = '0;
    end else if (consume) begin
      cnt_d = cnt_q + CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (res) begin
      occ_q     <= '0;
      head_q    <= '0;
      tail_q    <= '0;
      pending_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      occ_q     <= occ_d;
      head_q    <= head_d;
      tail_q    <= tail_d;
      pending_q <= pending_d;
      cnt_q     <= cnt_d;
    end
  end

  // Storage needs no reset: occupancy alone decides what is visible.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Bench for fifo_stream_reader: queue-based FIFO and stream model compared every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_fifo_stream_reader;
  localparam int W  = 8;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          res = 1'b1;
  logic          en = 1'b0;
  logic          clr_cnt = 1'b0;
  logic          fifo_empty = 1'b1;
  logic          out_ready = 1'b0;
  logic [W-1:0]  fifo_rdata = '0;
  logic          fifo_shift_out;
  logic          out_valid;
  logic          idle;
  logic [W-1:0]  out_data;
  logic [CW-1:0] words_out;

  int total = 0;
  int bad   = 0;

  fifo_stream_reader #(.WIDTH(W), .CNT_WIDTH(CW)) dut (
    .clk(clk), .res(res), .en(en), .clr_cnt(clr_cnt),
    .fifo_empty(fifo_empty), .fifo_rdata(fifo_rdata),
    .fifo_shift_out(fifo_shift_out), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .words_out(words_out), .idle(idle)
  );

  always #5 clk = ~clk;

  logic [W-1:0] fifo_q[$];
  logic [W-1:0] exp_stream[$];
  logic [W-1:0] m_buf[$];
  bit           m_inflight = 1'b0;
  int           m_cnt = 0;
  bit           m_pop, m_cons, dut_pop_s, res_s, clr_s;
  int           pops = 0;
  int           cons = 0;
  logic [W-1:0] last_data = '0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
    end
  endtask

  task automatic push(input logic [W-1:0] w);
    fifo_q.push_back(w);
    exp_stream.push_back(w);
    fifo_empty = 1'b0;
  endtask

  // Compare phase, on the falling edge.
  task automatic check();
    logic [W-1:0] e;
    m_pop  = en && (fifo_q.size() != 0) && (m_buf.size() + int'(m_inflight) < 3) && !res;
    m_cons = (m_buf.size() != 0) && out_ready;
    chk("shift_out", 32'(fifo_shift_out), 32'(m_pop));
    chk("out_valid", 32'(out_valid), 32'(m_buf.size() != 0));
    if (m_buf.size() != 0) chk("out_data", 32'(out_data), 32'(m_buf[0]));
    chk("words_out", 32'(words_out), 32'(m_cnt));
    chk("idle", 32'(idle), 32'((m_buf.size() == 0) && !m_inflight));
    chk("occ_pending_le3",
        32'(({1'b0, dut.occ_q} + {2'b00, dut.pending_q}) <= 3'd3), 32'(1));
    if (fifo_shift_out === 1'b1) pops++;
    if (out_valid === 1'b1 && out_ready && !res) begin
      cons++;
      last_data = out_data;
      if (exp_stream.size() == 0) begin
        total++;
        bad++;
        $display("FAIL stream_order: got=%0h expected=none", out_data);
      end else begin
        e = exp_stream.pop_front();
        chk("stream_order", 32'(out_data), 32'(e));
      end
    end
    dut_pop_s = (fifo_shift_out === 1'b1);
    res_s     = res;
    clr_s     = clr_cnt;
  endtask

  // Model/environment update, just after the rising edge.
  task automatic update();
    if (res_s) begin
      m_buf.delete();
      m_inflight = 1'b0;
      m_cnt      = 0;
      fifo_q.delete();
      exp_stream.delete();
      fifo_empty = 1'b1;
    end else begin
      if (m_cons) void'(m_buf.pop_front());
      if (m_inflight) m_buf.push_back(fifo_rdata);
      m_inflight = m_pop;
      if (dut_pop_s) begin
        if (fifo_q.size() != 0) fifo_rdata = fifo_q.pop_front();
        else fifo_rdata = 8'hEE;
      end
      fifo_empty = (fifo_q.size() == 0);
      if (clr_s) m_cnt = 0;
      else if (m_cons) m_cnt = (m_cnt + 1) % (1 << CW);
    end
  endtask

  task automatic step();
    @(negedge clk);
    check();
    @(posedge clk);
    #1;
    update();
  endtask

  task automatic do_reset();
    res = 1'b1;
    step();
    res = 1'b0;
  endtask

  task automatic drain(input int max_cycles, input string name);
    int n;
    n = 0;
    out_ready = 1'b1;
    while ((exp_stream.size() != 0 || m_inflight || m_buf.size() != 0) && n < max_cycles) begin
      step();
      n++;
    end
    chk(name, 32'(n < max_cycles), 32'(1));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int sent;
    // Reset state
    res = 1'b1;
    step();
    #1;
    chk("rst_valid", 32'(out_valid), 32'(0));
    chk("rst_idle", 32'(idle), 32'(1));
    chk("rst_words", 32'(words_out), 32'(0));
    chk("rst_shift", 32'(fifo_shift_out), 32'(0));
    res = 1'b0;

    // 1: three words, first visible two cycles after the first pop
    en = 1'b1;
    out_ready = 1'b1;
    push(8'h11); push(8'h22); push(8'h33);
    step(); step(); #1;
    chk("t1_valid0", 32'(out_valid), 32'(1));
    chk("t1_data0", 32'(out_data), 32'(8'h11));
    step(); #1;
    chk("t1_data1", 32'(out_data), 32'(8'h22));
    step(); #1;
    chk("t1_data2", 32'(out_data), 32'(8'h33));
    step(); #1;
    chk("t1_valid_end", 32'(out_valid), 32'(0));
    chk("t1_words", 32'(words_out), 32'(3));
    chk("t1_idle", 32'(idle), 32'(1));

    // 2: backpressure with 8 queued words
    do_reset();
    out_ready = 1'b0;
    for (int i = 0; i < 8; i++) push(W'(8'hA0 + i));
    pops = 0;
    repeat (6) step();
    #1;
    chk("t2_pops", 32'(pops), 32'(3));
    chk("t2_valid", 32'(out_valid), 32'(1));
    chk("t2_data", 32'(out_data), 32'(8'hA0));
    chk("t2_shift", 32'(fifo_shift_out), 32'(0));
    chk("t2_occ", 32'(dut.occ_q), 32'(3));
    out_ready = 1'b1;
    cons = 0;
    repeat (8) step();
    chk("t2_rate", 32'(cons), 32'(8));
    chk("t2_last", 32'(last_data), 32'(8'hA7));

    // 4: en dropped right after a pop
    do_reset();
    out_ready = 1'b1;
    push(8'h5A); push(8'h5B);
    step();
    en = 1'b0;
    pops = 0;
    cons = 0;
    repeat (4) step();
    chk("t4_pops", 32'(pops), 32'(0));
    chk("t4_cons", 32'(cons), 32'(1));
    chk("t4_word", 32'(last_data), 32'(8'h5A));
    en = 1'b1;
    drain(20, "t4_drain");
    chk("t4_last", 32'(last_data), 32'(8'h5B));

    // 6: reset with occ=2 and a word in flight
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) push(W'(8'h60 + i));
    repeat (3) step();
    #1;
    chk("t6_occ", 32'(dut.occ_q), 32'(2));
    chk("t6_pending", 32'(dut.pending_q), 32'(1));
    res = 1'b1;
    step(); #1;
    chk("t6_valid", 32'(out_valid), 32'(0));
    chk("t6_idle", 32'(idle), 32'(1));
    chk("t6_words", 32'(words_out), 32'(0));
    chk("t6_shift", 32'(fifo_shift_out), 32'(0));
    res = 1'b0;
    out_ready = 1'b1;
    cons = 0;
    repeat (3) step();
    chk("t6_no_ghost", 32'(cons), 32'(0));
    push(8'h77);
    drain(20, "t6_drain");
    chk("t6_first_after", 32'(last_data), 32'(8'h77));

    // 5: counter wrap and clear priority (CW=4)
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 17; i++) push(W'(8'h80 + i));
    drain(60, "t5_drain");
    #1;
    chk("t5_wrap", 32'(words_out), 32'(1));
    push(8'h90); push(8'h91);
    step(); step(); #1;
    chk("t5_valid", 32'(out_valid), 32'(1));
    clr_cnt = 1'b1;
    step(); #1;
    chk("t5_clr", 32'(words_out), 32'(0));
    clr_cnt = 1'b0;
    step(); #1;
    chk("t5_after_clr", 32'(words_out), 32'(1));

    // 3: random ready and random FIFO fill, 1000 words
    do_reset();
    sent = 0;
    cons = 0;
    for (int c = 0; c < 20000 && (sent < 1000 || exp_stream.size() != 0); c++) begin
      out_ready = 1'($urandom_range(0, 1));
      if (sent < 1000 && $urandom_range(0, 1) == 1) begin
        push(W'(sent * 7 + 3));
        sent++;
      end
      step();
    end
    drain(50, "t3_drain");
    chk("t3_count", 32'(cons), 32'(1000));
    #1;
    chk("t3_words", 32'(words_out), 32'(1000 % 16));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
